// File: rtl/packet_transmitter_pkg.sv
// Shared constants for the packet transmitter: default divider/FIFO depth,
// serializer state encoding and per-byte bit count (PACKET_TX_PARITY_EN).
package packet_transmitter_pkg;

   localparam int TX_CLK_DIV    = 4;
   localparam int TX_FIFO_DEPTH = 4;

`ifdef PACKET_TX_PARITY_EN
   localparam int TX_BITS_PER_BYTE = 9;
`else
   localparam int TX_BITS_PER_BYTE = 8;
`endif

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_SHIFT = 2'd2
   } tx_state_e;

   function automatic logic even_parity(input logic [7:0] b);
      return ^b;
   endfunction

endpackage

// File: rtl/tx_word_fifo.sv
// Word FIFO for the packet transmitter: show-ahead read port,
// occupancy counter, pointers wrapping at DEPTH (power of two).
module tx_word_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)
            rd_ptr <= rd_ptr + 1'b1;
         unique case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // storage needs no reset; occupancy guards every read
   always_ff @(posedge clk) begin
      if (do_push)
         mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/packet_transmitter.sv
// Back-pressured word-to-serial transmitter: FIFO plus IDLE/LOAD/SHIFT
// serializer. Define PACKET_TX_PARITY_EN to append even parity per byte.
module packet_transmitter
   import packet_transmitter_pkg::*;
#(
   parameter int BYTES      = 8,
   parameter int CLK_DIV    = TX_CLK_DIV,
   parameter int FIFO_DEPTH = TX_FIFO_DEPTH
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [8*BYTES-1:0] in_data,
   output logic               busy,
   output logic               transmission,
   output logic               clock,
   output logic               out_data
);

   localparam int BPB    = TX_BITS_PER_BYTE;
   localparam int F      = BYTES * BPB;
   localparam int PERIOD = 2 * CLK_DIV;
   localparam int BIT_W  = $clog2(F);
   localparam int DIV_W  = $clog2(PERIOD);

   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(F - 1);
   localparam logic [DIV_W-1:0] LAST_DIV = DIV_W'(PERIOD - 1);
   localparam logic [DIV_W-1:0] HIGH_DIV = DIV_W'(CLK_DIV);

   tx_state_e          state;
   tx_state_e          next_state;
   logic [8*BYTES-1:0] head;
   logic               full;
   logic               empty;
   logic               pop;
   logic [F-1:0]       frame;
   logic [F-1:0]       shreg;
   logic [BIT_W-1:0]   bit_cnt;
   logic [DIV_W-1:0]   div_cnt;
   logic               period_end;
   logic               last_bit;

   tx_word_fifo #(
      .WIDTH (8 * BYTES),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (in_valid),
      .pop   (pop),
      .wdata (in_data),
      .rdata (head),
      .full  (full),
      .empty (empty)
   );

   assign in_ready   = !full;
   assign busy       = !empty || (state != ST_IDLE);
   assign period_end = (div_cnt == LAST_DIV);
   assign last_bit   = (bit_cnt == LAST_BIT);

   // frame is emitted from the MSB: byte 0 first, each byte MSB first
   always_comb begin
      frame = '0;
      for (int k = 0; k < BYTES; k++) begin
         for (int j = 0; j < 8; j++)
            frame[F-1-k*BPB-j] = head[8*k+7-j];
`ifdef PACKET_TX_PARITY_EN
         frame[F-1-k*BPB-8] = even_parity(head[8*k +: 8]);
`endif
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         state <= ST_IDLE;
      else
         state <= next_state;
   end

   always_comb begin
      next_state = state;
      unique case (state)
         ST_IDLE:
            if (!empty)
               next_state = ST_LOAD;
         ST_LOAD:
            next_state = ST_SHIFT;
         ST_SHIFT:
            if (period_end && last_bit)
               next_state = empty ? ST_IDLE : ST_LOAD;
         default:
            next_state = ST_IDLE;
      endcase
   end

   always_comb begin
      pop          = (state == ST_LOAD);
      transmission = (state == ST_SHIFT);
      clock        = transmission && (div_cnt >= HIGH_DIV);
      out_data     = transmission && shreg[F-1];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         shreg   <= '0;
         bit_cnt <= '0;
         div_cnt <= '0;
      end else begin
         unique case (state)
            ST_LOAD: begin
               shreg   <= frame;
               bit_cnt <= '0;
               div_cnt <= '0;
            end
            ST_SHIFT: begin
               if (period_end) begin
                  div_cnt <= '0;
                  if (!last_bit) begin
                     bit_cnt <= bit_cnt + 1'b1;
                     shreg   <= shreg << 1;
                  end
               end else begin
                  div_cnt <= div_cnt + 1'b1;
               end
            end
            default: begin
               bit_cnt <= bit_cnt;
               div_cnt <= div_cnt;
            end
         endcase
      end
   end

endmodule

// File: doc/packet_transmitter.md
# packet_transmitter

Parametrised word-to-serial transmitter: accepts words of `BYTES` bytes over a valid/ready handshake, buffers them in an internal FIFO, and shifts them out as a contiguous clocked serial frame per word. It is the next-generation, back-pressured successor of the fixed 64-bit transmitter. It sits between producer logic and the external serial link (`clock`, `out_data`, `transmission`).

## Interface
- `BYTES`, 8, bytes per word; `in_data` width is 8*BYTES; range 1..16
- `CLK_DIV`, 4, `clk` cycles per half serial bit; range ≥1
- `FIFO_DEPTH`, 4, words buffered; power of two, ≥2
- `clk`  in  1  system clock; all logic on posedge
- `rst`  in  1  reset, asynchronous, active-low
- `in_valid`  in  1  producer presents a word
- `in_ready`  out  1  FIFO can accept a word
- `in_data`  in  8*BYTES  word; byte k = `in_data[8k+7:8k]`
- `busy`  out  1  FIFO non-empty or frame in progress
- `transmission`  out  1  high for the whole serial frame of a word
- `clock`  out  1  serial bit clock
- `out_data`  out  1  serial data

## Operation
- Word is accepted on a posedge where `in_valid && in_ready`; `in_ready = !full`, independent of a same-cycle pop; no push when full.
- FIFO holds words in order; the occupancy counter is clog2(FIFO_DEPTH+1) bits wide; pointers wrap at FIFO_DEPTH.
- Serializer states: IDLE, LOAD, SHIFT.
  - IDLE → LOAD when the FIFO is non-empty.
  - LOAD pops one word into the shift register and clears the bit and divider counters; → SHIFT.
  - SHIFT emits bits; after the last bit period → LOAD if the FIFO is non-empty, else → IDLE.
- Bit order: byte 0 first, each byte MSB first.
- Each byte is 8 bits, or 9 with parity (see Configuration).
- Frame length: F = BYTES*8 (or BYTES*9) bits; no gaps inside a frame.
- Bit period: 2*CLK_DIV cycles.
  - `out_data` changes at period start.
  - `clock` is low for the first CLK_DIV cycles and high for the second; the receiver samples on the rising edge.
- `transmission` is high during SHIFT only. Between back-to-back frames it drops low for exactly one cycle (the LOAD cycle).
- Idle outputs: `clock`=0, `out_data`=0, `transmission`=0.

## Timing
- Reset values: `in_ready`=1, `busy`=0, `transmission`=0, `clock`=0, `out_data`=0; FIFO empty, state IDLE.
- Reset takes effect immediately (asynchronous) and may assert mid-frame: the frame is aborted, FIFO contents are discarded, and no partial bits follow.
- Latency: a word accepted at edge T into an empty FIFO with the serializer in IDLE:
  - `busy`=1 after T.
  - LOAD at T+1; `transmission`=1 and the first bit on `out_data` after T+2.
- Frame duration: F*2*CLK_DIV cycles of `transmission` high.
- `busy` falls in the cycle after the last bit period ends, when the FIFO is empty.
- Simultaneous push and pop with the FIFO at FIFO_DEPTH-1 or lower: both occur and occupancy is unchanged.

## Configuration
- `PACKET_TX_PARITY_EN` defined: a 9th bit, even parity of the byte (XOR of its 8 bits), follows each byte's LSB; F = BYTES*9.
- Undefined: no parity bit; F = BYTES*8.

## Structure
- Shared constants file: default `TX_CLK_DIV`, `TX_FIFO_DEPTH`, serializer state encodings (IDLE=0, LOAD=1, SHIFT=2).
- One sub-module: `tx_word_fifo` (parameters WIDTH, DEPTH; push/pop/full/empty, asynchronous active-low reset). The serializer stays in the top level.

## Test plan
- BYTES=2, CLK_DIV=2, no parity, push 0xA55A → `out_data` sampled on `clock` rising edges = 0101_1010_1010_0101; `transmission` high 64 cycles; first bit 2 cycles after accept.
- Push 5 words with FIFO_DEPTH=4 while holding the serializer busy → `in_ready`=0 after the 4th stored word; 5th accepted after the first pop; all 5 transmitted in order, each separated by a 1-cycle `transmission` low.
- With `PACKET_TX_PARITY_EN`, BYTES=1, push 0x07 → bits 0000_0111 then parity 1; 9 rising edges of `clock`.
- Assert `rst` low mid-frame (bit 5 of 16) → `transmission`/`clock`/`out_data`=0 immediately; `busy`=0; the queued word is not sent after release.
- Idle check: no `in_valid` for 100 cycles after reset → `clock` stays 0, `busy`=0, `in_ready`=1.
- Push and pop in the same cycle with occupancy 2 → occupancy stays 2; word order preserved.
